// File: rtl/raster_scan_pkg.sv
// Shared types and default geometry widths for the down-counting raster tracker.
// No logic; imported by the tracker and its counters.
package raster_scan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } scan_state_e;

    localparam int CW_DEF = 10;
    localparam int RW_DEF = 9;

endpackage

// File: rtl/raster_down_scan_counter_down.sv
// Loadable down counter with reload-on-zero; zero pulse registered 1 cycle after the terminal dec.
// No backpressure: load wins over dec, dec at zero reloads instead of wrapping.
module counter_down
    import raster_scan_pkg::*;
#(
    parameter int N = CW_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] d,
    input  logic         dec,
    input  logic [N-1:0] reload_val,
    output logic [N-1:0] q,
    output logic         zero
);

    logic [N-1:0] q_d, q_q;
    logic         zero_d, zero_q;

    always_comb begin
        q_d    = q_q;
        zero_d = 1'b0;
        if (load) begin
            q_d = d;
        end else if (dec) begin
            if (q_q == '0) begin
                q_d    = reload_val;
                zero_d = 1'b1;
            end else begin
                q_d = q_q - N'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q    <= '0;
            zero_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            zero_q <= zero_d;
        end
    end

    assign q    = q_q;
    assign zero = zero_q;

endmodule

// File: rtl/raster_down_scan.sv
// Down-counting raster tracker: counts remaining pixels per dec, eol/eof pulses 1 cycle after the last pixel.
// No backpressure: dec is consumed whenever RUN; load restarts the frame at any time.
module raster_down_scan
    import raster_scan_pkg::*;
#(
    parameter int CW = CW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] cols_m1,
    input  logic [RW-1:0] rows_m1,
    input  logic          dec,
    output logic [CW-1:0] col_q,
    output logic [RW-1:0] row_q,
    output logic          busy,
    output logic          eol,
    output logic          eof
);

    scan_state_e   state_d, state_q;
    logic          busy_d, busy_q;
    logic [CW-1:0] col_len_d, col_len_q;

    logic          run_dec;
    logic          col_at_zero;
    logic          row_at_zero;
    logic          row_dec;
    logic [CW-1:0] col_reload;

    assign col_at_zero = (col_q == '0);
    assign row_at_zero = (row_q == '0);

    // load suppresses the dec so a restart never produces a pulse
    assign run_dec = (state_q == RUN) && dec && !load;
    assign row_dec = run_dec && col_at_zero;

    // On the final pixel the column must park at 0 instead of reloading
    assign col_reload = row_at_zero ? '0 : col_len_q;

    always_comb begin
        state_d   = state_q;
        col_len_d = col_len_q;
        if (load) begin
            state_d   = RUN;
            col_len_d = cols_m1;
        end else if (row_dec && row_at_zero) begin
            state_d = IDLE;
        end
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            col_len_q <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            col_len_q <= col_len_d;
        end
    end

    counter_down #(.N(CW)) u_col (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .d          (cols_m1),
        .dec        (run_dec),
        .reload_val (col_reload),
        .q          (col_q),
        .zero       (eol)
    );

    counter_down #(.N(RW)) u_row (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .d          (rows_m1),
        .dec        (row_dec),
        .reload_val ('0),
        .q          (row_q),
        .zero       (eof)
    );

    assign busy = busy_q;

endmodule

// File: tb/tb_raster_down_scan.sv
// Bench for raster_down_scan: hand-derived vector table, reset/toggle sequences, random vs. frame model.
module tb_raster_down_scan;

    localparam int CW = 10;
    localparam int RW = 9;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          load = 1'b0;
    logic [CW-1:0] cols_m1 = '0;
    logic [RW-1:0] rows_m1 = '0;
    logic          dec = 1'b0;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic          busy, eol, eof;

    int tests = 0;
    int fails = 0;

    raster_down_scan #(.CW(CW), .RW(RW)) dut (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .cols_m1 (cols_m1),
        .rows_m1 (rows_m1),
        .dec     (dec),
        .col_q   (col_q),
        .row_q   (row_q),
        .busy    (busy),
        .eol     (eol),
        .eof     (eof)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          ld;
        logic [CW-1:0] c;
        logic [RW-1:0] r;
        logic          d;
        logic [CW-1:0] e_col;
        logic [RW-1:0] e_row;
        logic          e_busy;
        logic          e_eol;
        logic          e_eof;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic ld, input int c, input int r, input logic d,
                                input int ec, input int er, input logic eb,
                                input logic el, input logic ef);
        vec_t v;
        v.ld = ld; v.c = CW'(c); v.r = RW'(r); v.d = d;
        v.e_col = CW'(ec); v.e_row = RW'(er);
        v.e_busy = eb; v.e_eol = el; v.e_eof = ef;
        return v;
    endfunction

    // Frame model: position counted in pixels consumed, geometry from the last load
    int  m_cols, m_rows, m_pos;
    bit  m_busy, m_eol, m_eof;
    int  m_col, m_row;

    task automatic model_reset();
        m_cols = 0; m_rows = 0; m_pos = 0;
        m_busy = 0; m_eol = 0; m_eof = 0; m_col = 0; m_row = 0;
    endtask

    task automatic model_step(input bit l, input int c, input int r, input bit d);
        int w;
        m_eol = 0;
        m_eof = 0;
        if (l) begin
            m_cols = c; m_rows = r; m_pos = 0; m_busy = 1;
            m_col = c; m_row = r;
        end else if (m_busy && d) begin
            m_pos++;
            w = m_cols + 1;
            if (m_pos == w * (m_rows + 1)) begin
                m_eol = 1; m_eof = 1; m_busy = 0; m_col = 0; m_row = 0;
            end else begin
                m_eol = (m_pos % w == 0);
                m_col = m_cols - (m_pos % w);
                m_row = m_rows - (m_pos / w);
            end
        end
    endtask

    task automatic check(input string name, input int ec, input int er,
                         input bit eb, input bit el, input bit ef);
        tests++;
        if (col_q !== CW'(ec) || row_q !== RW'(er) || busy !== eb || eol !== el || eof !== ef) begin
            fails++;
            $display("FAIL %s: got col=%0d row=%0d busy=%b eol=%b eof=%b, want col=%0d row=%0d busy=%b eol=%b eof=%b",
                     name, col_q, row_q, busy, eol, eof, ec, er, eb, el, ef);
        end
    endtask

    task automatic drive(input bit l, input int c, input int r, input bit d);
        load = l; cols_m1 = CW'(c); rows_m1 = RW'(r); dec = d;
        @(posedge clk);
        #1;
    endtask

    task automatic model_cycle(input string name, input bit l, input int c, input int r, input bit d);
        drive(l, c, r, d);
        model_step(l, c, r, d);
        check(name, m_col, m_row, m_busy, m_eol, m_eof);
    endtask

    initial begin
        // Reset state
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Table: 3/1 frame back-to-back, 1x1 frame, idle decs, mid-frame reload
        tbl.push_back(mk(1, 3, 1, 0, 3, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 2, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 3, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 2, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 1));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3, 1, 0, 3, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 2, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 3, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 2, 0, 1, 0, 0));
        tbl.push_back(mk(1, 2, 0, 1, 2, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].ld, int'(tbl[i].c), int'(tbl[i].r), tbl[i].d);
            check($sformatf("tbl[%0d]", i), int'(tbl[i].e_col), int'(tbl[i].e_row),
                  tbl[i].e_busy, tbl[i].e_eol, tbl[i].e_eof);
        end

        // dec toggling 1/0 over a 3/1 frame: counts hold on idle cycles
        model_reset();
        model_cycle("toggle_load", 1, 3, 1, 0);
        for (int i = 0; i < 18; i++)
            model_cycle($sformatf("toggle[%0d]", i), 0, 0, 0, (i % 2) == 0);

        // Async reset mid-frame at col_q=5, then decs ignored in IDLE
        drive(1, 7, 2, 0);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        check("pre_reset_col5", 5, 2, 1, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 10; i++)
            model_cycle($sformatf("idle_dec[%0d]", i), 0, 0, 0, 1);

        // Random geometry, dec and restarts against the frame model
        for (int i = 0; i < 3000; i++) begin
            bit l;
            l = m_busy ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 3) == 0);
            model_cycle("random", l, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                        $urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
